// File: rtl/sxr_vector_sequencer.sv
// Test-vector sequencer for sxrRISC621 bring-up: replays a table of
// {dut reset, switches, expected display, mask} into the processor, holds each
// vector for HOLD_CYCLES clocks, and scores the display against the table.
module sxr_vector_sequencer #(
    parameter int SW_W        = 5,
    parameter int DISP_W      = 8,
    parameter int AW          = 6,
    parameter int HOLD_CYCLES = 2,
    parameter int ERR_W       = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Loop_en,
    input  logic [AW:0]       Num_vec,
    input  logic              Wr_en,
    input  logic [AW-1:0]     Wr_addr,
    input  logic [SW_W:0]     Wr_stim,
    input  logic [DISP_W-1:0] Wr_exp,
    input  logic [DISP_W-1:0] Wr_mask,
    input  logic [DISP_W-1:0] DUT_disp,
    output logic              DUT_resetn,
    output logic [SW_W-1:0]   DUT_sw,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [ERR_W-1:0]  Err_count,
    output logic [AW-1:0]     First_fail,
    output logic [AW-1:0]     Step
);

    localparam int DEPTH = 1 << AW;
    localparam int HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_V   = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t state, state_nxt;

    // Vector table; contents survive reset so a loaded table can be rerun.
    logic [SW_W:0]     stim_mem [DEPTH];
    logic [DISP_W-1:0] exp_mem  [DEPTH];
    logic [DISP_W-1:0] mask_mem [DEPTH];

    logic [HW-1:0]   hold_cnt;
    logic [AW-1:0]   last_idx;
    logic            stop_seen;

    logic            start_ok;
    logic [AW:0]     nv_clamped;
    logic            last_hold;
    logic            is_last;
    logic            end_run;
    logic            mismatch;
    logic [AW-1:0]   next_step;
    logic [SW_W:0]   stim0;

    // Run control decode shared by the FSM and the datapath.
    always_comb begin
        start_ok   = (state != APPLY) && Start;
        nv_clamped = (Num_vec > DEPTH_V) ? DEPTH_V : Num_vec;
        last_hold  = (state == APPLY) && (hold_cnt == '0);
        is_last    = (Step == last_idx);
        // Stop on the final hold edge counts the same as an earlier Stop.
        end_run    = last_hold && (Stop || stop_seen || (is_last && !Loop_en));
        next_step  = is_last ? '0 : Step + 1'b1;
        // Entries that hold the DUT in reset are never scored.
        mismatch   = last_hold && stim_mem[Step][SW_W] &&
                     (|((DUT_disp ^ exp_mem[Step]) & mask_mem[Step]));
        // A write to entry 0 on the Start edge must reach the DUT immediately.
        stim0      = (Wr_en && (Wr_addr == '0)) ? Wr_stim : stim_mem[0];
    end

    // Table write port, locked out while a run is in progress.
    always_ff @(posedge Clock) begin
        if (Wr_en && !Busy) begin
            stim_mem[Wr_addr] <= Wr_stim;
            exp_mem[Wr_addr]  <= Wr_exp;
            mask_mem[Wr_addr] <= Wr_mask;
        end
    end

    // FSM state register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // FSM next state and status outputs.
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        Pass      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (Start) state_nxt = (nv_clamped != '0) ? APPLY : DONE;
            end
            APPLY: begin
                if (end_run) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
        Busy = (state == APPLY);
        Done = (state == DONE);
        Pass = (state == DONE) && (Err_count == '0);
    end

    // Vector drive, hold timing and scoring.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            DUT_resetn <= 1'b0;
            DUT_sw     <= '0;
            Err_count  <= '0;
            First_fail <= '1;
            Step       <= '0;
            hold_cnt   <= HOLD_LAST;
            last_idx   <= '0;
            stop_seen  <= 1'b0;
        end else if (start_ok) begin
            Err_count  <= '0;
            First_fail <= '1;
            Step       <= '0;
            hold_cnt   <= HOLD_LAST;
            stop_seen  <= 1'b0;
            if (nv_clamped != '0) begin
                last_idx             <= AW'(nv_clamped - 1'b1);
                {DUT_resetn, DUT_sw} <= stim0;
            end
        end else if (state == APPLY) begin
            if (mismatch) begin
                if (Err_count != '1)  Err_count  <= Err_count + 1'b1;
                if (First_fail == '1) First_fail <= Step;
            end
            if (last_hold) begin
                hold_cnt  <= HOLD_LAST;
                stop_seen <= 1'b0;
                // Next vector goes out on the scoring edge: no idle gap.
                if (!end_run) begin
                    Step                 <= next_step;
                    {DUT_resetn, DUT_sw} <= stim_mem[next_step];
                end
            end else begin
                hold_cnt <= hold_cnt - 1'b1;
                if (Stop) stop_seen <= 1'b1;
            end
        end
    end

endmodule
